// File: rtl/invaders_pkg.sv
// Shared encodings and widths for the invader formation logic.
package invaders_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DROP   = 2'd2,
    ST_LANDED = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int XOFF_W = 5;
  localparam int YOFF_W = 4;
  localparam int TPS_W  = 4;

endpackage

// File: rtl/tick_divider.sv
// Divides timer ticks by a programmable ticks-per-step value with a speed-up floor.
// due is combinational from tick so the parent can act on the same clock edge.
module tick_divider
  import invaders_pkg::*;
#(
  parameter int TICKS_INIT = 8,
  parameter int TICKS_MIN  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  input  logic speedup,
  input  logic reload,
  output logic due
);

  localparam logic [TPS_W-1:0] TPS_INIT_V = TPS_W'(TICKS_INIT);
  localparam logic [TPS_W-1:0] TPS_MIN_V  = TPS_W'(TICKS_MIN);

  logic [TPS_W-1:0] tick_cnt;
  logic [TPS_W-1:0] tps;

  // >= rather than == so a step is not lost when tps shrinks below tick_cnt.
  assign due = tick && (tick_cnt >= (tps - TPS_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      tps      <= TPS_INIT_V;
    end else if (reload) begin
      tick_cnt <= '0;
      tps      <= TPS_INIT_V;
    end else begin
      if (clr || due) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + TPS_W'(1);
      end
      if (speedup && (tps > TPS_MIN_V)) begin
        tps <= tps - TPS_W'(1);
      end
    end
  end

endmodule

// File: rtl/march_stepper.sv
// Converts timer ticks into invader march steps: sideways moves, and a row drop
// with direction reversal at each edge, until the formation lands.
module march_stepper
  import invaders_pkg::*;
#(
  parameter int X_MAX      = 15,
  parameter int Y_MAX      = 7,
  parameter int TICKS_INIT = 8,
  parameter int TICKS_MIN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic              tick,
  input  logic              speedup,
  output logic              tmr_clr,
  output logic [XOFF_W-1:0] x_off,
  output logic [YOFF_W-1:0] y_off,
  output logic              dir,
  output logic              step,
  output logic              landed,
  output state_e            state_dbg
);

  localparam logic [XOFF_W-1:0] XMAX_V = XOFF_W'(X_MAX);
  localparam logic [YOFF_W-1:0] YMAX_V = YOFF_W'(Y_MAX);

  state_e            state;
  logic              due;
  logic              at_edge;
  logic [YOFF_W-1:0] y_next;

  assign state_dbg = state;
  assign at_edge   = ((dir == DIR_RIGHT) && (x_off == XMAX_V)) ||
                     ((dir == DIR_LEFT)  && (x_off == '0));
  assign y_next    = y_off + YOFF_W'(1);

  // Ticks only count while running; pausing discards the partial count.
  tick_divider #(
    .TICKS_INIT(TICKS_INIT),
    .TICKS_MIN (TICKS_MIN)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .clr    (!en),
    .tick   (tick && en && (state == ST_RUN)),
    .speedup(speedup && (state != ST_LANDED)),
    .reload (restart),
    .due    (due)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tmr_clr <= 1'b0;
      x_off   <= '0;
      y_off   <= '0;
      dir     <= DIR_RIGHT;
      step    <= 1'b0;
      landed  <= 1'b0;
    end else if (restart) begin
      state   <= ST_IDLE;
      tmr_clr <= 1'b0;
      x_off   <= '0;
      y_off   <= '0;
      dir     <= DIR_RIGHT;
      step    <= 1'b0;
      landed  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state   <= ST_RUN;
            tmr_clr <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state   <= ST_IDLE;
            tmr_clr <= 1'b0;
          end else if (due) begin
            if (at_edge) begin
              state <= ST_DROP;
            end else begin
              x_off <= (dir == DIR_RIGHT) ? x_off + XOFF_W'(1) : x_off - XOFF_W'(1);
              step  <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          // Pausing here abandons the drop entirely.
          if (!en) begin
            state   <= ST_IDLE;
            tmr_clr <= 1'b0;
          end else begin
            y_off <= y_next;
            dir   <= ~dir;
            step  <= 1'b1;
            if (y_next == YMAX_V) begin
              state   <= ST_LANDED;
              tmr_clr <= 1'b0;
              landed  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_LANDED: begin
          landed  <= 1'b1;
          tmr_clr <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          tmr_clr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_stepper.sv
// Bench for march_stepper: directed scenarios plus randomized traffic against a reference model.
module tb_march_stepper;
  import invaders_pkg::*;

  localparam int MX = 15;
  localparam int MY = 7;
  localparam int TI = 8;
  localparam int TMIN = 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_DROP = 2;
  localparam int M_LANDED = 3;

  logic clk = 1'b0;
  logic reset;
  logic en = 1'b0;
  logic restart = 1'b0;
  logic tick = 1'b0;
  logic speedup = 1'b0;

  logic       tmr_clr, dir, step, landed;
  logic [4:0] x_off;
  logic [3:0] y_off;
  state_e     state_dbg;

  logic       tmr_clr_s, dir_s, step_s, landed_s;
  logic [4:0] x_off_s;
  logic [3:0] y_off_s;
  state_e     state_dbg_s;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_mode = M_IDLE;
  int m_x = 0;
  int m_y = 0;
  int m_cnt = 0;
  int m_tps = TI;
  bit m_dir = 1'b1;
  bit m_step = 1'b0;

  march_stepper dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .tick(tick), .speedup(speedup),
    .tmr_clr(tmr_clr), .x_off(x_off), .y_off(y_off), .dir(dir), .step(step),
    .landed(landed), .state_dbg(state_dbg)
  );

  march_stepper #(.X_MAX(1), .Y_MAX(2), .TICKS_INIT(1), .TICKS_MIN(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .tick(tick), .speedup(speedup),
    .tmr_clr(tmr_clr_s), .x_off(x_off_s), .y_off(y_off_s), .dir(dir_s), .step(step_s),
    .landed(landed_s), .state_dbg(state_dbg_s)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_x = 0;
    m_y = 0;
    m_cnt = 0;
    m_tps = TI;
    m_dir = 1'b1;
    m_step = 1'b0;
  endtask

  always @(posedge clk or negedge reset) begin : mdl
    int  mode_before;
    bit  edge_hit;
    if (!reset || restart) begin
      model_reset();
    end else begin
      mode_before = m_mode;
      edge_hit = m_dir ? (m_x == MX) : (m_x == 0);
      m_step = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (!en) m_cnt = 0;
          else m_mode = M_RUN;
        end
        M_RUN: begin
          if (!en) begin
            m_mode = M_IDLE;
            m_cnt = 0;
          end else if (tick) begin
            if (m_cnt + 1 >= m_tps) begin
              m_cnt = 0;
              if (edge_hit) m_mode = M_DROP;
              else begin
                m_x = m_x + (m_dir ? 1 : -1);
                m_step = 1'b1;
              end
            end else begin
              m_cnt = m_cnt + 1;
            end
          end
        end
        M_DROP: begin
          if (!en) begin
            m_mode = M_IDLE;
            m_cnt = 0;
          end else begin
            m_y = m_y + 1;
            m_dir = !m_dir;
            m_step = 1'b1;
            m_mode = (m_y == MY) ? M_LANDED : M_RUN;
          end
        end
        default: ;
      endcase
      if (speedup && mode_before != M_LANDED)
        m_tps = (m_tps - 1 < TMIN) ? TMIN : m_tps - 1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart_run();
    en = 1'b1;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({tmr_clr, x_off, y_off, dir, step, landed} !== {1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got tmr=%b x=%0d y=%0d dir=%b step=%b landed=%b want 0 0 0 1 0 0",
               tmr_clr, x_off, y_off, dir, step, landed);
    end
    checks++;
    if ({tmr_clr_s, x_off_s, y_off_s, dir_s, step_s, landed_s} !== {1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values_small got tmr=%b x=%0d y=%0d dir=%b landed=%b",
               tmr_clr_s, x_off_s, y_off_s, dir_s, landed_s);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (state_dbg !== ST_IDLE || tmr_clr !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_release got state=%0d tmr=%b want 0 0", state_dbg, tmr_clr);
    end
  endtask

  task automatic test_first_step();
    en = 1'b1;
    cycle();
    checks++;
    if (tmr_clr !== 1'b1) begin
      failures++;
      $display("FAIL tmr_clr_after_en got %b want 1", tmr_clr);
    end
    for (int i = 1; i <= 8; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      checks++;
      if (i < 8) begin
        if (step !== 1'b0 || x_off !== 5'd0) begin
          failures++;
          $display("FAIL early_tick_%0d got step=%b x=%0d want 0 0", i, step, x_off);
        end
      end else if (step !== 1'b1 || x_off !== 5'd1 || dir !== 1'b1) begin
        failures++;
        $display("FAIL eighth_tick got step=%b x=%0d dir=%b want 1 1 1", step, x_off, dir);
      end
      cycle();
      if (i == 8) begin
        checks++;
        if (step !== 1'b0) begin
          failures++;
          $display("FAIL step_one_cycle got %b want 0", step);
        end
      end
      repeat (10) cycle();
    end
  endtask

  task automatic test_march_drop();
    int nsteps = 0;
    restart_run();
    for (int i = 1; i <= 128; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      if (i <= 127 && step === 1'b1) nsteps++;
      if (i == 128) begin
        checks++;
        if (x_off !== 5'd15 || y_off !== 4'd0 || step !== 1'b0) begin
          failures++;
          $display("FAIL drop_entry got x=%0d y=%0d step=%b want 15 0 0", x_off, y_off, step);
        end
      end
      cycle();
      if (i <= 127 && step === 1'b1) nsteps++;
      if (i == 128) begin
        checks++;
        if (y_off !== 4'd1 || dir !== 1'b0 || x_off !== 5'd15 || step !== 1'b1) begin
          failures++;
          $display("FAIL drop_applied got y=%0d dir=%b x=%0d step=%b want 1 0 15 1",
                   y_off, dir, x_off, step);
        end
      end
      cycle();
    end
    checks++;
    if (nsteps != 15) begin
      failures++;
      $display("FAIL step_count got %0d want 15", nsteps);
    end
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      repeat (2) cycle();
    end
    checks++;
    if (x_off !== 5'd14 || dir !== 1'b0) begin
      failures++;
      $display("FAIL march_left got x=%0d dir=%b want 14 0", x_off, dir);
    end
  endtask

  task automatic test_speedup();
    restart_run();
    speedup = 1'b1;
    repeat (10) cycle();
    speedup = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      checks++;
      if (step !== 1'b1 || x_off !== 5'(i)) begin
        failures++;
        $display("FAIL fast_tick_%0d got step=%b x=%0d want 1 %0d", i, step, x_off, i);
      end
      repeat (2) cycle();
    end
    // tps shrinks below the running count
    restart_run();
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      repeat (2) cycle();
    end
    speedup = 1'b1;
    repeat (5) cycle();
    speedup = 1'b0;
    checks++;
    if (x_off !== 5'd0) begin
      failures++;
      $display("FAIL shrink_pre got x=%0d want 0", x_off);
    end
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    checks++;
    if (step !== 1'b1 || x_off !== 5'd1) begin
      failures++;
      $display("FAIL shrink_step got step=%b x=%0d want 1 1", step, x_off);
    end
    // tick coincident with speedup is judged against the old tps
    restart_run();
    for (int i = 0; i < 6; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      repeat (2) cycle();
    end
    tick = 1'b1;
    speedup = 1'b1;
    cycle();
    tick = 1'b0;
    speedup = 1'b0;
    checks++;
    if (step !== 1'b0 || x_off !== 5'd0) begin
      failures++;
      $display("FAIL tick_with_speedup got step=%b x=%0d want 0 0", step, x_off);
    end
    repeat (2) cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    checks++;
    if (step !== 1'b1 || x_off !== 5'd1) begin
      failures++;
      $display("FAIL tick_after_speedup got step=%b x=%0d want 1 1", step, x_off);
    end
  endtask

  task automatic test_pause();
    int nsteps = 0;
    restart_run();
    for (int i = 0; i < 13; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      repeat (2) cycle();
    end
    en = 1'b0;
    cycle();
    checks++;
    if (tmr_clr !== 1'b0 || x_off !== 5'd1 || y_off !== 4'd0 || dir !== 1'b1) begin
      failures++;
      $display("FAIL pause_hold got tmr=%b x=%0d y=%0d dir=%b want 0 1 0 1", tmr_clr, x_off, y_off, dir);
    end
    repeat (3) cycle();
    en = 1'b1;
    cycle();
    checks++;
    if (tmr_clr !== 1'b1) begin
      failures++;
      $display("FAIL resume_tmr got %b want 1", tmr_clr);
    end
    for (int i = 1; i <= 8; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      if (i < 8 && step === 1'b1) nsteps++;
      if (i == 8) begin
        checks++;
        if (nsteps != 0 || step !== 1'b1 || x_off !== 5'd2) begin
          failures++;
          $display("FAIL resume_count got early=%0d step=%b x=%0d want 0 1 2", nsteps, step, x_off);
        end
      end
      repeat (2) cycle();
    end
  endtask

  task automatic test_landed();
    restart_run();
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      repeat (2) cycle();
    end
    checks++;
    if ({landed_s, tmr_clr_s, y_off_s, x_off_s, dir_s} !== {1'b1, 1'b0, 4'd2, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL landed_state got landed=%b tmr=%b y=%0d x=%0d dir=%b want 1 0 2 0 1",
               landed_s, tmr_clr_s, y_off_s, x_off_s, dir_s);
    end
    for (int i = 0; i < 8; i++) begin
      en = i[0];
      tick = ~i[0];
      speedup = i[1];
      cycle();
      checks++;
      if ({landed_s, tmr_clr_s, y_off_s, x_off_s, dir_s, step_s} !==
          {1'b1, 1'b0, 4'd2, 5'd0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL landed_hold_%0d got landed=%b tmr=%b y=%0d x=%0d dir=%b step=%b",
                 i, landed_s, tmr_clr_s, y_off_s, x_off_s, dir_s, step_s);
      end
    end
    tick = 1'b0;
    speedup = 1'b0;
    en = 1'b1;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    checks++;
    if ({landed_s, tmr_clr_s, y_off_s, x_off_s, dir_s} !== {1'b0, 1'b0, 4'd0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL landed_restart got landed=%b tmr=%b y=%0d x=%0d dir=%b want 0 0 0 0 1",
               landed_s, tmr_clr_s, y_off_s, x_off_s, dir_s);
    end
  endtask

  task automatic test_reset_in_drop();
    restart_run();
    speedup = 1'b1;
    repeat (10) cycle();
    speedup = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      if (i < 15) repeat (2) cycle();
    end
    checks++;
    if (state_dbg !== ST_DROP || x_off !== 5'd15 || y_off !== 4'd0) begin
      failures++;
      $display("FAIL in_drop got state=%0d x=%0d y=%0d want 2 15 0", state_dbg, x_off, y_off);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({tmr_clr, x_off, y_off, dir, step, landed} !== {1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got tmr=%b x=%0d y=%0d dir=%b step=%b landed=%b",
               tmr_clr, x_off, y_off, dir, step, landed);
    end
    @(negedge clk);
    reset = 1'b1;
    cycle();
    checks++;
    if (y_off !== 4'd0 || x_off !== 5'd0 || tmr_clr !== 1'b1) begin
      failures++;
      $display("FAIL after_reset got y=%0d x=%0d tmr=%b want 0 0 1", y_off, x_off, tmr_clr);
    end
  endtask

  task automatic test_random();
    int since_tick = 3;
    bit prev_step = 1'b0;
    logic [12:0] got_v, exp_v;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 19) != 0);
      speedup = ($urandom_range(0, 39) == 0);
      restart = ($urandom_range(0, 299) == 0);
      tick = (since_tick >= 3) && ($urandom_range(0, 2) == 0);
      since_tick = tick ? 1 : since_tick + 1;
      cycle();
      got_v = {tmr_clr, x_off, y_off, dir, step, landed};
      exp_v = {(m_mode == M_RUN || m_mode == M_DROP), 5'(m_x), 4'(m_y), m_dir, m_step,
               (m_mode == M_LANDED)};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL random_cycle_%0d got tmr,x,y,dir,step,landed=%b want %b", i, got_v, exp_v);
      end
      checks++;
      if (prev_step && step === 1'b1) begin
        failures++;
        $display("FAIL step_twice cycle %0d got step=1 twice want isolated pulse", i);
      end
      prev_step = (step === 1'b1);
    end
    en = 1'b0;
    tick = 1'b0;
    speedup = 1'b0;
    restart = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_first_step();
    test_march_drop();
    test_speedup();
    test_pause();
    test_landed();
    test_reset_in_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
